truth_table_sweeper: RTL and testbench

//  Sequential, parametrised truth-table engine for the lab logic blocks. On start it sweeps all
//  2**N_IN input rows in ascending binary order and evaluates a selectable logic function per row.

---
 rtl/tt_pkg.sv | 27 ++
 rtl/truth_table_sweeper_if.sv | 36 +++
 rtl/tt_logic_fn.sv | 55 +++++
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_truth_table_sweeper.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : tt_pkg                                                            |
// | Purpose : Shared mode codes and FSM state encoding for the truth-table      |
// |           sweeper.                                                          |
// | Rev     : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
package tt_pkg;

    // Logic function select codes (3 bits)
    localparam logic [2:0] TT_INHIBIT = 3'd0;
    localparam logic [2:0] TT_AND     = 3'd1;
    localparam logic [2:0] TT_OR      = 3'd2;
    localparam logic [2:0] TT_XOR     = 3'd3;
    localparam logic [2:0] TT_NAND    = 3'd4;
    localparam logic [2:0] TT_NOR     = 3'd5;
    localparam logic [2:0] TT_XNOR    = 3'd6;
    localparam logic [2:0] TT_MAJ     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : truth_table_sweeper_if                                          |
// | Purpose   : Control inputs and row-stream outputs of the sweeper.           |
// |   start, mode, out_ready              : driven by master (consumer/bench)   |
// |   out_valid, out_vec, out_s, busy,                                          |
// |   done, minterm_mask, ones_count      : driven by slave (sweeper)           |
// | Rev       : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
) ();
    localparam int CNT_W = N_IN + 1;

    logic                 start;
    logic [2:0]           mode;
    logic                 out_ready;
    logic                 out_valid;
    logic [N_IN-1:0]      out_vec;
    logic                 out_s;
    logic                 busy;
    logic                 done;
    logic [(2**N_IN)-1:0] minterm_mask;
    logic [CNT_W-1:0]     ones_count;

    modport master (
        output start, mode, out_ready,
        input  out_valid, out_vec, out_s, busy, done, minterm_mask, ones_count
    );

    modport slave (
        input  start, mode, out_ready,
        output out_valid, out_vec, out_s, busy, done, minterm_mask, ones_count
    );
endinterface
`default_nettype wire

// File: rtl/tt_logic_fn.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tt_logic_fn                                                       |
// | Purpose : Combinational decode of the selectable logic function.            |
// |   i_x    [N_IN] : input row, bit N_IN-1 is the MSB                          |
// |   i_mode [3]    : function select (tt_pkg TT_* codes)                       |
// |   o_s           : function result                                           |
// | Rev     : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tt_logic_fn
    import tt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  wire logic [N_IN-1:0] i_x,
    input  wire logic [2:0]      i_mode,
    output logic                 o_s
);
    localparam logic [3:0] c_HALF = 4'(N_IN / 2);

    logic       w_inh;
    logic [3:0] w_pop;

    // With a single input there is no lower slice to AND, so inhibit is just ~x[0].
    generate
        if (N_IN == 1) begin : g_inh_one
            assign w_inh = ~i_x[0];
        end else begin : g_inh_multi
            assign w_inh = ~i_x[N_IN-1] & (&i_x[N_IN-2:0]);
        end
    endgenerate

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < N_IN; i++) begin
            w_pop = w_pop + {3'b000, i_x[i]};
        end
    end

    always_comb begin
        o_s = 1'b0;
        case (i_mode)
            TT_INHIBIT: o_s = w_inh;
            TT_AND:     o_s = &i_x;
            TT_OR:      o_s = |i_x;
            TT_XOR:     o_s = ^i_x;
            TT_NAND:    o_s = ~(&i_x);
            TT_NOR:     o_s = ~(|i_x);
            TT_XNOR:    o_s = ~(^i_x);
            TT_MAJ:     o_s = (w_pop > c_HALF);
            default:    o_s = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : truth_table_sweeper                                               |
// | Purpose : Sweeps all 2**N_IN input rows in ascending order, streams each    |
// |           row and its function result over valid/ready, and accumulates a  |
// |           minterm mask and ones count.                                      |
// |   clk   : clock, rising edge                                                |
// |   rst_n : asynchronous active-low reset                                     |
// |   bus   : truth_table_sweeper_if.slave (start/mode/out_ready in;            |
// |           out_valid/out_vec/out_s/busy/done/minterm_mask/ones_count out)    |
// | Rev     : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    truth_table_sweeper_if.slave bus
);
    localparam int              CNT_W      = N_IN + 1;
    localparam int              NROWS      = 2 ** N_IN;
    localparam logic [N_IN:0]   c_LAST_ROW = (N_IN + 1)'(NROWS - 1);

    state_t             r_state;
    state_t             w_next;
    // One extra bit so the increment after the final row never aliases row 0.
    logic [N_IN:0]      r_row;
    logic [2:0]         r_mode;
    logic [NROWS-1:0]   r_mask;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_fn;
    logic               w_run;
    logic               w_fire;
    logic               w_start_ok;

    tt_logic_fn #(.N_IN(N_IN)) u_fn (
        .i_x    (r_row[N_IN-1:0]),
        .i_mode (r_mode),
        .o_s    (w_fn)
    );

    assign w_run      = (r_state == ST_RUN);
    assign w_fire     = w_run & bus.out_ready;
    assign w_start_ok = (r_state != ST_RUN) & bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire && (r_row == c_LAST_ROW)) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_mode <= 3'd0;
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (w_start_ok) begin
            r_row  <= '0;
            r_mode <= bus.mode;
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (w_fire) begin
            r_mask[r_row[N_IN-1:0]] <= w_fn;
            r_cnt                   <= r_cnt + CNT_W'(w_fn);
            r_row                   <= r_row + 1'b1;
        end
    end

    // Row outputs are forced low outside RUN so reset/DONE show all zeros
    // even for functions that are true on row 0.
    assign bus.out_valid    = w_run;
    assign bus.busy         = w_run;
    assign bus.done         = (r_state == ST_DONE);
    assign bus.out_vec      = w_run ? r_row[N_IN-1:0] : '0;
    assign bus.out_s        = w_run & w_fn;
    assign bus.minterm_mask = r_mask;
    assign bus.ones_count   = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_truth_table_sweeper                                            |
// | Purpose : Directed self-checking bench; three sweeper instances with        |
// |           N_IN = 1, 2 and 3 sharing clock and reset.                        |
// | Rev     : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(1)) if1 ();
    truth_table_sweeper_if #(.N_IN(2)) if2 ();
    truth_table_sweeper_if #(.N_IN(3)) if3 ();

    truth_table_sweeper #(.N_IN(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    truth_table_sweeper #(.N_IN(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    truth_table_sweeper #(.N_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [2:0] m);
        if1.mode = m; if1.start = 1'b1; tick(); if1.start = 1'b0;
    endtask
    task automatic start2(input logic [2:0] m);
        if2.mode = m; if2.start = 1'b1; tick(); if2.start = 1'b0;
    endtask
    task automatic start3(input logic [2:0] m);
        if3.mode = m; if3.start = 1'b1; tick(); if3.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({if1.out_valid, if1.busy, if1.done, if1.out_s, if1.out_vec, if1.minterm_mask, if1.ones_count} !== '0) begin
            bad++; $display("FAIL reset_n1 got=%b exp=0", {if1.out_valid, if1.busy, if1.done, if1.out_s, if1.out_vec, if1.minterm_mask, if1.ones_count});
        end
        total++;
        if ({if2.out_valid, if2.busy, if2.done, if2.out_s, if2.out_vec, if2.minterm_mask, if2.ones_count} !== '0) begin
            bad++; $display("FAIL reset_n2 got=%b exp=0", {if2.out_valid, if2.busy, if2.done, if2.out_s, if2.out_vec, if2.minterm_mask, if2.ones_count});
        end
        total++;
        if ({if3.out_valid, if3.busy, if3.done, if3.out_s, if3.out_vec, if3.minterm_mask, if3.ones_count} !== '0) begin
            bad++; $display("FAIL reset_n3 got=%b exp=0", {if3.out_valid, if3.busy, if3.done, if3.out_s, if3.out_vec, if3.minterm_mask, if3.ones_count});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // N_IN=2, INHIBIT: rows 00,01,10,11 -> 0,1,0,0
    task automatic test_inhibit_n2();
        logic [3:0] e = 4'b0010;
        if2.out_ready = 1'b1;
        start2(3'd0);
        for (int r = 0; r < 4; r++) begin
            total++;
            if (if2.out_valid !== 1'b1 || if2.out_vec !== 2'(r) || if2.out_s !== e[r]) begin
                bad++; $display("FAIL inh_row%0d got v=%b vec=%0d s=%b exp v=1 vec=%0d s=%b", r, if2.out_valid, if2.out_vec, if2.out_s, r, e[r]);
            end
            tick();
        end
        total++;
        if (if2.done !== 1'b1 || if2.busy !== 1'b0 || if2.out_valid !== 1'b0) begin
            bad++; $display("FAIL inh_done got d=%b b=%b v=%b exp d=1 b=0 v=0", if2.done, if2.busy, if2.out_valid);
        end
        total++;
        if (if2.minterm_mask !== 4'b0010 || if2.ones_count !== 3'd1) begin
            bad++; $display("FAIL inh_result got mask=%b cnt=%0d exp mask=0010 cnt=1", if2.minterm_mask, if2.ones_count);
        end
    endtask

    // N_IN=3, XOR with ready held high
    task automatic test_xor_n3();
        logic [7:0] e = 8'b1001_0110;
        if3.out_ready = 1'b1;
        start3(3'd3);
        for (int r = 0; r < 8; r++) begin
            total++;
            if (if3.out_vec !== 3'(r) || if3.out_s !== e[r]) begin
                bad++; $display("FAIL xor_row%0d got vec=%0d s=%b exp vec=%0d s=%b", r, if3.out_vec, if3.out_s, r, e[r]);
            end
            tick();
        end
        total++;
        if (if3.done !== 1'b1 || if3.minterm_mask !== 8'b1001_0110 || if3.ones_count !== 4'd4) begin
            bad++; $display("FAIL xor_result got d=%b mask=%b cnt=%0d exp d=1 mask=10010110 cnt=4", if3.done, if3.minterm_mask, if3.ones_count);
        end
    endtask

    // N_IN=3, MAJ with ready pattern 1,0,0,1 repeating; each row must hold until accepted
    task automatic test_maj_backpressure_n3();
        logic [7:0] e = 8'b1110_1000;
        int   exp_row = 0;
        int   cyc     = 0;
        logic rdy;
        if3.out_ready = 1'b0;
        start3(3'd7);
        while (exp_row < 8 && cyc < 100) begin
            total++;
            if (if3.out_valid !== 1'b1 || if3.out_vec !== 3'(exp_row) || if3.out_s !== e[exp_row]) begin
                bad++; $display("FAIL maj_cyc%0d got v=%b vec=%0d s=%b exp v=1 vec=%0d s=%b", cyc, if3.out_valid, if3.out_vec, if3.out_s, exp_row, e[exp_row]);
            end
            rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if3.out_ready = rdy;
            tick();
            if (rdy) exp_row++;
            cyc++;
        end
        total++;
        if (exp_row != 8) begin
            bad++; $display("FAIL maj_timeout got rows=%0d exp rows=8", exp_row);
        end
        total++;
        if (if3.done !== 1'b1 || if3.minterm_mask !== 8'b1110_1000 || if3.ones_count !== 4'd4) begin
            bad++; $display("FAIL maj_result got d=%b mask=%b cnt=%0d exp d=1 mask=11101000 cnt=4", if3.done, if3.minterm_mask, if3.ones_count);
        end
        if3.out_ready = 1'b1;
    endtask

    // N_IN=2: mode change and start re-pulse mid-RUN must be ignored
    task automatic test_ignore_midrun_n2();
        if2.out_ready = 1'b1;
        start2(3'd0);
        tick();
        if2.mode  = 3'd1;
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        total++;
        if (if2.busy !== 1'b1 || if2.out_vec !== 2'd2) begin
            bad++; $display("FAIL ign_row2 got b=%b vec=%0d exp b=1 vec=2", if2.busy, if2.out_vec);
        end
        tick();
        total++;
        if (if2.out_vec !== 2'd3 || if2.out_s !== 1'b0) begin
            bad++; $display("FAIL ign_row3 got vec=%0d s=%b exp vec=3 s=0", if2.out_vec, if2.out_s);
        end
        tick();
        total++;
        if (if2.done !== 1'b1 || if2.minterm_mask !== 4'b0010 || if2.ones_count !== 3'd1) begin
            bad++; $display("FAIL ign_result got d=%b mask=%b cnt=%0d exp d=1 mask=0010 cnt=1", if2.done, if2.minterm_mask, if2.ones_count);
        end
        if2.mode = 3'd0;
    endtask

    // N_IN=3: async reset after third transfer, then a complete new sweep
    task automatic test_reset_midsweep_n3();
        int n = 0;
        if3.out_ready = 1'b1;
        start3(3'd3);
        tick(); tick(); tick();
        total++;
        if (if3.out_vec !== 3'd3 || if3.minterm_mask !== 8'b0000_0110 || if3.ones_count !== 4'd2) begin
            bad++; $display("FAIL rstm_partial got vec=%0d mask=%b cnt=%0d exp vec=3 mask=00000110 cnt=2", if3.out_vec, if3.minterm_mask, if3.ones_count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({if3.out_valid, if3.busy, if3.done, if3.out_s, if3.out_vec, if3.minterm_mask, if3.ones_count} !== '0) begin
            bad++; $display("FAIL rstm_clear got=%b exp=0", {if3.out_valid, if3.busy, if3.done, if3.out_s, if3.out_vec, if3.minterm_mask, if3.ones_count});
        end
        tick();
        rst_n = 1'b1;
        tick();
        start3(3'd3);
        while (if3.busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL rstm_cycles got=%0d exp=8", n);
        end
        total++;
        if (if3.done !== 1'b1 || if3.minterm_mask !== 8'b1001_0110 || if3.ones_count !== 4'd4) begin
            bad++; $display("FAIL rstm_result got d=%b mask=%b cnt=%0d exp d=1 mask=10010110 cnt=4", if3.done, if3.minterm_mask, if3.ones_count);
        end
    endtask

    // N_IN=1: INHIBIT sweep, then restarts from DONE with NAND and AND
    task automatic test_restart_n1();
        if1.out_ready = 1'b1;
        start1(3'd0);
        total++;
        if (if1.out_vec !== 1'b0 || if1.out_s !== 1'b1) begin
            bad++; $display("FAIL n1_row0 got vec=%b s=%b exp vec=0 s=1", if1.out_vec, if1.out_s);
        end
        tick(); tick();
        total++;
        if (if1.done !== 1'b1 || if1.minterm_mask !== 2'b01 || if1.ones_count !== 2'd1) begin
            bad++; $display("FAIL n1_inh got d=%b mask=%b cnt=%0d exp d=1 mask=01 cnt=1", if1.done, if1.minterm_mask, if1.ones_count);
        end
        start1(3'd4);
        total++;
        if (if1.done !== 1'b0 || if1.busy !== 1'b1 || if1.minterm_mask !== 2'b00 || if1.ones_count !== 2'd0) begin
            bad++; $display("FAIL n1_restart got d=%b b=%b mask=%b cnt=%0d exp d=0 b=1 mask=00 cnt=0", if1.done, if1.busy, if1.minterm_mask, if1.ones_count);
        end
        tick(); tick();
        total++;
        if (if1.done !== 1'b1 || if1.minterm_mask !== 2'b01 || if1.ones_count !== 2'd1) begin
            bad++; $display("FAIL n1_nand got d=%b mask=%b cnt=%0d exp d=1 mask=01 cnt=1", if1.done, if1.minterm_mask, if1.ones_count);
        end
        start1(3'd1);
        tick(); tick();
        total++;
        if (if1.done !== 1'b1 || if1.minterm_mask !== 2'b10 || if1.ones_count !== 2'd1) begin
            bad++; $display("FAIL n1_and got d=%b mask=%b cnt=%0d exp d=1 mask=10 cnt=1", if1.done, if1.minterm_mask, if1.ones_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if1.start = 1'b0; if1.mode = 3'd0; if1.out_ready = 1'b0;
        if2.start = 1'b0; if2.mode = 3'd0; if2.out_ready = 1'b0;
        if3.start = 1'b0; if3.mode = 3'd0; if3.out_ready = 1'b0;
        test_reset();
        test_inhibit_n2();
        test_xor_n3();
        test_maj_backpressure_n3();
        test_ignore_midrun_n2();
        test_reset_midsweep_n3();
        test_restart_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
